// File: rtl/pc_unit_if.sv
// Bundle between the control unit / ALU and the program-counter unit.
// The master side drives branch strobes and operands; the slave (pc_unit) returns PC state.
interface pc_unit_if #(
  parameter int ADDR_W = 64
);
  logic              stall;
  logic              uncond_branch;
  logic              reg_branch;
  logic              zero_branch;
  logic              nzero_branch;
  logic              flag_branch;
  logic [3:0]        cond;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] reg_target;
  logic              zero_in;
  logic              flag_write;
  logic [3:0]        flags_in;
  logic              halt_req;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        flags;
  logic              instr_valid;
  logic              branch_taken;
  logic              halted;
  logic              align_fault;

  modport master (
    output stall, uncond_branch, reg_branch, zero_branch, nzero_branch,
           flag_branch, cond, branch_offset, reg_target, zero_in,
           flag_write, flags_in, halt_req,
    input  pc, flags, instr_valid, branch_taken, halted, align_fault
  );

  modport slave (
    input  stall, uncond_branch, reg_branch, zero_branch, nzero_branch,
           flag_branch, cond, branch_offset, reg_target, zero_in,
           flag_write, flags_in, halt_req,
    output pc, flags, instr_valid, branch_taken, halted, align_fault
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter, NZCV flag register and next-PC resolution for the LEGv8 core.
// Handles B, BR, CBZ, CBNZ, B.cond plus stall, a one-cycle boot state and halt.
module pc_unit #(
  parameter int          ADDR_W      = 64,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          INSTR_BYTES = 4,
  parameter int          ALIGN_BITS  = 2
) (
  input logic       clk,
  input logic       reset_n,
  pc_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } state_t;

  localparam logic [ADDR_W-1:0] LP_RESET_PC = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LP_STEP     = ADDR_W'(INSTR_BYTES);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [3:0]        r_flags;
  logic              r_instr_valid;
  logic              r_halted;
  logic              r_align_fault;

  logic [ADDR_W-1:0] w_seq_target;
  logic [ADDR_W-1:0] w_rel_target;
  logic [ADDR_W-1:0] w_redirect_target;
  logic              w_take;
  logic              w_misaligned;
  logic              w_fault;
  logic              w_cond_pass;

  // Condition evaluation on {N,Z,C,V}; AL and NV both pass.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cf;
      4'h3:    cond_pass = !cf;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cf && !z;
      4'h9:    cond_pass = !(cf && !z);
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = !(!z && (n == v));
      default: cond_pass = 1'b1;
    endcase
  endfunction

  assign w_seq_target = r_pc + LP_STEP;
  assign w_rel_target = r_pc + bus.branch_offset;
  // B.cond always looks at the registered flags, never at flags_in.
  assign w_cond_pass  = cond_pass(bus.cond, r_flags);

  // Only the highest-priority asserted strobe is considered; a lower strobe
  // cannot take over when a higher conditional one is not taken.
  always_comb begin
    w_take            = 1'b0;
    w_redirect_target = w_rel_target;
    if (bus.halt_req) begin
      w_take = 1'b0;
    end else if (bus.reg_branch) begin
      w_take            = 1'b1;
      w_redirect_target = bus.reg_target;
    end else if (bus.uncond_branch) begin
      w_take = 1'b1;
    end else if (bus.zero_branch) begin
      w_take = bus.zero_in;
    end else if (bus.nzero_branch) begin
      w_take = !bus.zero_in;
    end else if (bus.flag_branch) begin
      w_take = w_cond_pass;
    end
  end

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign w_misaligned = |w_redirect_target[ALIGN_BITS-1:0];
    end else begin : g_no_align
      assign w_misaligned = 1'b0;
    end
  endgenerate

  assign w_fault = w_take && w_misaligned;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= LP_RESET_PC;
      r_flags       <= 4'b0000;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_align_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state       <= ST_RUN;
          r_instr_valid <= 1'b1;
        end
        ST_RUN: begin
          if (!bus.stall) begin
            if (bus.flag_write) begin
              r_flags <= bus.flags_in;
            end
            if (bus.halt_req) begin
              r_state       <= ST_HALT;
              r_instr_valid <= 1'b0;
              r_halted      <= 1'b1;
            end else if (w_fault) begin
              // A misaligned redirect never reaches pc; the unit stops instead.
              r_state       <= ST_HALT;
              r_instr_valid <= 1'b0;
              r_halted      <= 1'b1;
              r_align_fault <= 1'b1;
            end else if (w_take) begin
              r_pc <= w_redirect_target;
            end else begin
              r_pc <= w_seq_target;
            end
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state       <= ST_HALT;
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc           = r_pc;
  assign bus.flags        = r_flags;
  assign bus.instr_valid  = r_instr_valid;
  assign bus.halted       = r_halted;
  assign bus.align_fault  = r_align_fault;
  assign bus.branch_taken = (r_state == ST_RUN) && w_take;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset/boot, all branch classes, flags, stall,
// wrap-around, misaligned target, halt and reset out of HALT.
module tb_pc_unit;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  pc_unit_if #(.ADDR_W(64)) bus ();

  pc_unit #(
    .ADDR_W(64),
    .RESET_PC(64'h0),
    .INSTR_BYTES(4),
    .ALIGN_BITS(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.stall         = 1'b0;
    bus.uncond_branch = 1'b0;
    bus.reg_branch    = 1'b0;
    bus.zero_branch   = 1'b0;
    bus.nzero_branch  = 1'b0;
    bus.flag_branch   = 1'b0;
    bus.cond          = 4'h0;
    bus.branch_offset = 64'h0;
    bus.reg_target    = 64'h0;
    bus.zero_in       = 1'b0;
    bus.flag_write    = 1'b0;
    bus.flags_in      = 4'h0;
    bus.halt_req      = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 64'h0);
    chk("rst_flags", 64'(bus.flags), 64'h0);
    chk("rst_iv", 64'(bus.instr_valid), 64'h0);
    chk("rst_halted", 64'(bus.halted), 64'h0);
    chk("rst_af", 64'(bus.align_fault), 64'h0);

    // BOOT: strobes are ignored and branch_taken stays low
    reset_n = 1'b1;
    bus.uncond_branch = 1'b1;
    bus.branch_offset = 64'h40;
    #1;
    chk("boot_iv", 64'(bus.instr_valid), 64'h0);
    chk("boot_bt", 64'(bus.branch_taken), 64'h0);
    step();
    chk("run0_pc", bus.pc, 64'h0);
    chk("run0_iv", 64'(bus.instr_valid), 64'h1);
    clr();
    step();
    chk("run1_pc", bus.pc, 64'h4);
    step();
    chk("run2_pc", bus.pc, 64'h8);

    // B and BR
    bus.reg_branch = 1'b1; bus.reg_target = 64'h100;
    step();
    chk("br100_pc", bus.pc, 64'h100);
    clr();
    bus.uncond_branch = 1'b1; bus.branch_offset = -64'sd16;
    #1;
    chk("b_bt", 64'(bus.branch_taken), 64'h1);
    step();
    chk("b_pc", bus.pc, 64'hF0);
    clr();
    bus.reg_branch = 1'b1; bus.reg_target = 64'h2000;
    #1;
    chk("br_bt", 64'(bus.branch_taken), 64'h1);
    step();
    chk("br_pc", bus.pc, 64'h2000);

    // reg_branch outranks uncond_branch
    clr();
    bus.reg_branch = 1'b1; bus.reg_target = 64'h40;
    bus.uncond_branch = 1'b1; bus.branch_offset = 64'h8;
    step();
    chk("prio_pc", bus.pc, 64'h40);

    // CBZ not taken, CBNZ taken
    clr();
    bus.zero_branch = 1'b1; bus.zero_in = 1'b0; bus.branch_offset = 64'h20;
    #1;
    chk("cbz_bt", 64'(bus.branch_taken), 64'h0);
    step();
    chk("cbz_pc", bus.pc, 64'h44);
    clr();
    bus.nzero_branch = 1'b1; bus.zero_in = 1'b0; bus.branch_offset = 64'h20;
    #1;
    chk("cbnz_bt", 64'(bus.branch_taken), 64'h1);
    step();
    chk("cbnz_pc", bus.pc, 64'h64);

    // B.EQ uses pre-update flags
    clr();
    bus.flag_write = 1'b1; bus.flags_in = 4'b0100;
    bus.flag_branch = 1'b1; bus.cond = 4'h0; bus.branch_offset = 64'h100;
    #1;
    chk("beq0_bt", 64'(bus.branch_taken), 64'h0);
    step();
    chk("beq0_pc", bus.pc, 64'h68);
    chk("beq0_flags", 64'(bus.flags), 64'h4);
    bus.flag_write = 1'b0;
    #1;
    chk("beq1_bt", 64'(bus.branch_taken), 64'h1);
    step();
    chk("beq1_pc", bus.pc, 64'h168);
    clr();
    bus.flag_write = 1'b1; bus.flags_in = 4'b1000;
    step();
    chk("setn_pc", bus.pc, 64'h16C);
    chk("setn_flags", 64'(bus.flags), 64'h8);
    clr();
    bus.flag_branch = 1'b1; bus.cond = 4'hC; bus.branch_offset = 64'h100;
    #1;
    chk("bgt_bt", 64'(bus.branch_taken), 64'h0);
    step();
    chk("bgt_pc", bus.pc, 64'h170);
    bus.cond = 4'hB; bus.branch_offset = 64'h10;
    #1;
    chk("blt_bt", 64'(bus.branch_taken), 64'h1);
    step();
    chk("blt_pc", bus.pc, 64'h180);

    // stall holds pc and flags, then the branch proceeds
    clr();
    bus.stall = 1'b1;
    bus.uncond_branch = 1'b1; bus.branch_offset = 64'h40;
    bus.flag_write = 1'b1; bus.flags_in = 4'b0011;
    #1;
    chk("stall_bt", 64'(bus.branch_taken), 64'h1);
    step();
    chk("stall1_pc", bus.pc, 64'h180);
    step();
    chk("stall2_pc", bus.pc, 64'h180);
    chk("stall2_flags", 64'(bus.flags), 64'h8);
    bus.stall = 1'b0;
    step();
    chk("unstall_pc", bus.pc, 64'h1C0);
    chk("unstall_flags", 64'(bus.flags), 64'h3);

    // wrap-around of the sequential increment
    clr();
    bus.reg_branch = 1'b1; bus.reg_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    chk("top_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    clr();
    step();
    chk("wrap_pc", bus.pc, 64'h0);
    step();
    chk("seq_pc", bus.pc, 64'h4);

    // halt_req: flag_write completes, pc holds, branch ignored
    bus.halt_req = 1'b1; bus.flag_write = 1'b1; bus.flags_in = 4'b1111;
    bus.reg_branch = 1'b1; bus.reg_target = 64'h500;
    #1;
    chk("halt_bt", 64'(bus.branch_taken), 64'h0);
    step();
    chk("halt_pc", bus.pc, 64'h4);
    chk("halt_flags", 64'(bus.flags), 64'hF);
    chk("halt_halted", 64'(bus.halted), 64'h1);
    chk("halt_iv", 64'(bus.instr_valid), 64'h0);
    chk("halt_af", 64'(bus.align_fault), 64'h0);
    clr();
    bus.uncond_branch = 1'b1; bus.branch_offset = 64'h80;
    bus.flag_write = 1'b1; bus.flags_in = 4'b0000;
    step();
    chk("halt_hold_pc", bus.pc, 64'h4);
    chk("halt_hold_flags", 64'(bus.flags), 64'hF);
    chk("halt_hold_bt", 64'(bus.branch_taken), 64'h0);

    // asynchronous reset out of HALT
    reset_n = 1'b0;
    #1;
    chk("rst2_pc", bus.pc, 64'h0);
    chk("rst2_halted", 64'(bus.halted), 64'h0);
    chk("rst2_flags", 64'(bus.flags), 64'h0);
    clr();
    step();
    reset_n = 1'b1;
    step();
    chk("boot2_iv", 64'(bus.instr_valid), 64'h1);
    step();
    chk("boot2_pc", bus.pc, 64'h4);

    // misaligned BR target
    bus.reg_branch = 1'b1; bus.reg_target = 64'h1002;
    #1;
    chk("mis_bt", 64'(bus.branch_taken), 64'h1);
    step();
    chk("mis_pc", bus.pc, 64'h4);
    chk("mis_af", 64'(bus.align_fault), 64'h1);
    chk("mis_halted", 64'(bus.halted), 64'h1);
    chk("mis_iv", 64'(bus.instr_valid), 64'h0);
    clr();
    bus.uncond_branch = 1'b1; bus.branch_offset = 64'h10;
    step();
    chk("mis_hold_pc", bus.pc, 64'h4);
    chk("mis_hold_af", 64'(bus.align_fault), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("rst3_af", 64'(bus.align_fault), 64'h0);
    chk("rst3_pc", bus.pc, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
